// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq: computes a WORDS-nibble wide add by stepping an
// external 4-bit adder slice once per cycle, LSB nibble first, with the
// carry chained through a register between nibbles.
module nibble_serial_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WORDS-1:0] in_a,
  input  logic [4*WORDS-1:0] in_b,
  input  logic               in_cin,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  output logic               add_cin,
  input  logic [3:0]         add_sum,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WORDS-1:0] out_sum,
  output logic               out_cout
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [WORDS-1:0][3:0]   op_a, op_b, res, res_nxt;
  logic                    carry, cout_r;
  logic [IW-1:0]           idx;
  logic                    last;

  assign last     = (idx == IW'(WORDS - 1));
  // cout_r only changes on the final nibble, so it doubles as the held output
  assign out_cout = cout_r;

  // Adder slice operands: current nibble while running, quiet zeros otherwise
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = op_a[idx];
      add_b   = op_b[idx];
      add_cin = carry;
    end
  end

  // Partial result with the current nibble's sum merged in
  always_comb begin
    res_nxt      = res;
    res_nxt[idx] = add_sum;
  end

  // Sequencer FSM; all handshake outputs and results are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      cout_r    <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      res       <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= in_a;
            op_b     <= in_b;
            carry    <= in_cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= add_cout;
          if (last) begin
            // top carry leaves the chain here; it never feeds nibble 0
            cout_r    <= add_cout;
            out_sum   <= res_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
